// File: rtl/fpadd_pipe_if.sv
// Stream interface of the pipelined floating-point adder.
// The producer/consumer side uses the master modport and the adder uses the slave modport.
interface fpadd_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;
    logic         ovf;
    logic         unf;
    logic         nan;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, z, ovf, unf, nan
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, z, ovf, unf, nan
    );
endinterface

// File: rtl/fpadd_pipe.sv
// Three-stage floating-point adder/subtractor: align, add, normalise/round/pack.
// Denormal inputs are flushed to zero, any all-ones exponent yields an all-ones NaN word,
// and rounding is round-to-nearest-even on guard/round/sticky bits.
// The interface instance must carry the same EXP_W/MAN_W as this module.
module fpadd_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic         clk,
    input  logic         rst_n,
    fpadd_pipe_if.slave  bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MW   = MAN_W + 4;              // hidden, mantissa, guard, round, sticky
    localparam int EW2  = EXP_W + 2;              // signed exponent working width
    localparam int LZ_W = $clog2(MW) + 1;

    localparam logic [EXP_W-1:0]      EXP_ONES  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0]      EXP_ZERO  = {EXP_W{1'b0}};
    localparam logic [EXP_W-1:0]      MAX_SHIFT = EXP_W'(MAN_W + 3);
    localparam logic signed [EW2-1:0] EXP_MAX_S = {2'b00, EXP_ONES};
    localparam logic signed [EW2-1:0] ZERO_S    = {EW2{1'b0}};
    localparam logic signed [EW2-1:0] ONE_S     = {{(EW2-1){1'b0}}, 1'b1};

    // Extended mantissa: hidden one (absent for zero/flushed operands) and three empty low bits.
    function automatic logic [MW-1:0] mant_ext(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        return {(e != EXP_ZERO), m, 3'b000};
    endfunction

    // Leading-zero count; an all-zero word returns MW.
    function automatic logic [LZ_W-1:0] lzc(input logic [MW-1:0] v);
        logic [LZ_W-1:0] n;
        logic            found;
        n     = LZ_W'(MW);
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = LZ_W'(MW - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // ---------------- handshake ----------------
    logic v1_q, v2_q, v3_q;
    logic load1_s, load2_s, load3_s;

    assign load3_s      = !v3_q || bus.out_ready;
    assign load2_s      = !v2_q || load3_s;
    assign load1_s      = !v1_q || load2_s;
    assign bus.in_ready = load1_s;

    // Stage valid bits advance whenever the stage below is empty or moving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            if (load1_s) v1_q <= bus.in_valid;
            if (load2_s) v2_q <= v1_q;
            if (load3_s) v3_q <= v2_q;
        end
    end

    // ---------------- stage 1: classify, swap, align ----------------
    logic [EXP_W-1:0] ea_s, eb_s, el_d, es_s, ediff_s;
    logic [MAN_W-1:0] ma_s, mb_s;
    logic             sa_s, sb_s, sl_d, ss_d, nan1_d;
    logic [MW-1:0]    ml_d, ms_ext_s, ms_d, lost_mask_s;

    // Order operands by magnitude and shift the smaller one right, keeping a sticky bit.
    always_comb begin
        ea_s = bus.a[W-2:MAN_W];
        eb_s = bus.b[W-2:MAN_W];
        sa_s = bus.a[W-1];
        sb_s = bus.b[W-1] ^ bus.sub;
        if (ea_s == EXP_ZERO) ma_s = {MAN_W{1'b0}};
        else                  ma_s = bus.a[MAN_W-1:0];
        if (eb_s == EXP_ZERO) mb_s = {MAN_W{1'b0}};
        else                  mb_s = bus.b[MAN_W-1:0];
        nan1_d = (ea_s == EXP_ONES) || (eb_s == EXP_ONES);
        if ({eb_s, mb_s} > {ea_s, ma_s}) begin
            el_d = eb_s; sl_d = sb_s; ml_d = mant_ext(eb_s, mb_s);
            es_s = ea_s; ss_d = sa_s; ms_ext_s = mant_ext(ea_s, ma_s);
        end else begin
            el_d = ea_s; sl_d = sa_s; ml_d = mant_ext(ea_s, ma_s);
            es_s = eb_s; ss_d = sb_s; ms_ext_s = mant_ext(eb_s, mb_s);
        end
        ediff_s     = el_d - es_s;
        lost_mask_s = ~({MW{1'b1}} << ediff_s);
        if (ediff_s > MAX_SHIFT) begin
            ms_d = {{(MW-1){1'b0}}, |ms_ext_s};
        end else begin
            ms_d = (ms_ext_s >> ediff_s) | {{(MW-1){1'b0}}, |(ms_ext_s & lost_mask_s)};
        end
    end

    logic             s1_sl_q, s1_ss_q, s1_nan_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [MW-1:0]    s1_ml_q, s1_ms_q;

    // Stage 1 datapath register, loaded on an input transfer.
    always_ff @(posedge clk) begin
        if (load1_s && bus.in_valid) begin
            s1_sl_q  <= sl_d;
            s1_ss_q  <= ss_d;
            s1_nan_q <= nan1_d;
            s1_exp_q <= el_d;
            s1_ml_q  <= ml_d;
            s1_ms_q  <= ms_d;
        end
    end

    // ---------------- stage 2: signed magnitude add ----------------
    logic [MW:0] sum_d;

    // Swap guarantees L >= S, so the difference never goes negative.
    always_comb begin
        if (s1_sl_q == s1_ss_q) sum_d = {1'b0, s1_ml_q} + {1'b0, s1_ms_q};
        else                    sum_d = {1'b0, s1_ml_q} - {1'b0, s1_ms_q};
    end

    logic             s2_sign_q, s2_nan_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [MW:0]      s2_sum_q;

    // Stage 2 datapath register.
    always_ff @(posedge clk) begin
        if (load2_s && v1_q) begin
            s2_sign_q <= s1_sl_q;
            s2_nan_q  <= s1_nan_q;
            s2_exp_q  <= s1_exp_q;
            s2_sum_q  <= sum_d;
        end
    end

    // ---------------- stage 3: normalise, round, pack ----------------
    logic [LZ_W-1:0]       lz_s;
    logic signed [EW2-1:0] exp_ext_s, exp_n_s, exp_f_s;
    logic [MW-1:0]         norm_s;
    logic                  round_up_s;
    logic [MAN_W+1:0]      man_r_s;
    logic [MAN_W-1:0]      frac_s;
    logic [W-1:0]          z_d;
    logic                  ovf_d, unf_d, nan_d;

    // Normalise the raw sum, round to nearest even, then classify overflow/underflow.
    always_comb begin
        lz_s      = lzc(s2_sum_q[MW-1:0]);
        exp_ext_s = {2'b00, s2_exp_q};
        if (s2_sum_q[MW]) begin
            norm_s  = {s2_sum_q[MW:2], s2_sum_q[1] | s2_sum_q[0]};
            exp_n_s = exp_ext_s + ONE_S;
        end else begin
            norm_s  = s2_sum_q[MW-1:0] << lz_s;
            exp_n_s = exp_ext_s - EW2'(lz_s);
        end
        round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        man_r_s    = {1'b0, norm_s[MW-1:3]} + {{(MAN_W+1){1'b0}}, round_up_s};
        if (man_r_s[MAN_W+1]) begin
            exp_f_s = exp_n_s + ONE_S;
            frac_s  = man_r_s[MAN_W:1];
        end else begin
            exp_f_s = exp_n_s;
            frac_s  = man_r_s[MAN_W-1:0];
        end
        z_d   = {W{1'b0}};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        nan_d = 1'b0;
        if (s2_nan_q) begin
            z_d   = {W{1'b1}};
            nan_d = 1'b1;
        end else if (s2_sum_q == {(MW+1){1'b0}}) begin
            z_d = {W{1'b0}};
        end else if (exp_f_s >= EXP_MAX_S) begin
            z_d   = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
            ovf_d = 1'b1;
        end else if (exp_f_s <= ZERO_S) begin
            z_d   = {W{1'b0}};
            unf_d = 1'b1;
        end else begin
            z_d = {s2_sign_q, exp_f_s[EXP_W-1:0], frac_s};
        end
    end

    logic [W-1:0] z_q;
    logic         ovf_q, unf_q, nan_q;

    // Output register: holds while stalled, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q   <= {W{1'b0}};
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            nan_q <= 1'b0;
        end else if (load3_s && v2_q) begin
            z_q   <= z_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            nan_q <= nan_d;
        end
    end

    assign bus.out_valid = v3_q;
    assign bus.z         = z_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;
    assign bus.nan       = nan_q;
endmodule

// File: tb/tb_fpadd_pipe.sv
// Scoreboard bench for fpadd_pipe (single precision).
// The reference model adds exactly with wide integers and rounds once to nearest even.
module tb_fpadd_pipe;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    int   rdy_mode;
    int   res_idx;

    typedef struct {
        logic [34:0] res;        // {nan, ovf, unf, z}
        int          issue_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t exp_q[$];

    fpadd_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fpadd_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Exact reference: value = r * 2^-149, then one rounding step.
    function automatic logic [34:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [299:0] ma, mb, r, rem, half, mq;
        logic         sa, sb, sr, rup;
        logic [24:0]  m25;
        int           ea, eb, p, e, sh;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) return {3'b100, 32'hFFFF_FFFF};
        sa = a[31];
        sb = b[31] ^ s;
        ma = (ea == 0) ? 300'd0 : (300'({1'b1, a[22:0]}) << (ea - 1));
        mb = (eb == 0) ? 300'd0 : (300'({1'b1, b[22:0]}) << (eb - 1));
        if (sa == sb)     begin r = ma + mb; sr = sa; end
        else if (ma >= mb) begin r = ma - mb; sr = sa; end
        else              begin r = mb - ma; sr = sb; end
        if (r == 300'd0) return 35'd0;
        p = 0;
        for (int i = 0; i < 300; i++) if (r[i]) p = i;
        e = p - 22;
        if (e <= 0) return {3'b001, 32'h0};
        sh   = p - 23;
        mq   = r >> sh;
        rem  = r & ((300'd1 << sh) - 300'd1);
        half = (sh > 0) ? (300'd1 << (sh - 1)) : 300'd0;
        rup  = (sh > 0) && ((rem > half) || ((rem == half) && mq[0]));
        m25  = mq[24:0] + {24'd0, rup};
        if (m25[24]) begin
            e   = e + 1;
            m25 = 25'h0800000;
        end
        if (e >= 255) return {3'b010, sr, 8'hFF, 23'd0};
        return {3'b000, sr, 8'(e), m25[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op(input int base_e);
        int e;
        int m;
        m = $urandom_range(0, 19);
        case (m)
            0:              e = 0;
            1:              e = 255;
            2:              e = 254;
            3, 4, 5, 6, 7, 8, 9, 10, 11: e = base_e + $urandom_range(0, 6) - 3;
            default:        e = $urandom_range(0, 255);
        endcase
        if (e < 0)   e = 0;
        if (e > 255) e = 255;
        return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit chk_lat, input logic [34:0] expv);
        int   waited;
        bit   done;
        exp_t ent;
        waited = 0;
        done   = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.sub      = s;
        while (!done) begin
            #4;
            if (bus.in_ready) begin
                ent.res       = expv;
                ent.issue_cyc = cyc;
                ent.chk_lat   = chk_lat;
                @(posedge clk);
                exp_q.push_back(ent);
                done = 1;
            end else begin
                waited++;
                if (waited > 100) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
                    bus.in_valid = 1'b0;
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic issue_rnd(input bit chk_lat);
        logic [31:0] a, b;
        logic        s;
        a = rnd_op($urandom_range(1, 254));
        if ($urandom_range(0, 7) == 0) b = {~a[31], a[30:0]};
        else                           b = rnd_op(int'(a[30:23]));
        s = 1'($urandom_range(0, 1));
        issue(a, b, s, chk_lat, ref_add(a, b, s));
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        idle();
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // out_ready pattern generator
    initial begin
        int pat;
        pat = 0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                1:       begin bus.out_ready = (pat % 3 == 0); pat++; end
                2:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: handshake, hold-while-stalled and result checking
    initial begin
        bit          stall_prev;
        logic [34:0] held;
        exp_t        ent;
        stall_prev = 0;
        held       = 35'd0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                stall_prev = 0;
            end else begin
                check("in_ready", 64'(bus.in_ready), 64'(!(exp_q.size() == 3 && !bus.out_ready)));
                if (stall_prev) begin
                    check("hold_valid", 64'(bus.out_valid), 64'd1);
                    check("hold_z", 64'({bus.nan, bus.ovf, bus.unf, bus.z}), 64'(held));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_output: z=%h with no outstanding operation", bus.z);
                    end else begin
                        ent = exp_q.pop_front();
                        check($sformatf("result[%0d]", res_idx), 64'({bus.nan, bus.ovf, bus.unf, bus.z}), 64'(ent.res));
                        if (ent.chk_lat) check($sformatf("latency[%0d]", res_idx), 64'(cyc - ent.issue_cyc), 64'd3);
                        res_idx++;
                    end
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                held       = {bus.nan, bus.ovf, bus.unf, bus.z};
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [34:0] r;
    } vec_t;

    vec_t vecs[$];

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        res_idx      = 0;
        rdy_mode     = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        bus.sub      = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #4;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_z_flags", 64'({bus.nan, bus.ovf, bus.unf, bus.z}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed vectors, each run through an unstalled pipe
        vecs.push_back('{32'h3F800000, 32'h40000000, 1'b0, {3'b000, 32'h40400000}});
        vecs.push_back('{32'h3F800000, 32'hBF800000, 1'b0, {3'b000, 32'h00000000}});
        vecs.push_back('{32'h3F800000, 32'h3F000000, 1'b1, {3'b000, 32'h3F000000}});
        vecs.push_back('{32'h3F800000, 32'h3F7FFFFF, 1'b1, {3'b000, 32'h33800000}});
        vecs.push_back('{32'h4B800000, 32'h3F800000, 1'b0, {3'b000, 32'h4B800000}});
        vecs.push_back('{32'h4B800001, 32'h3F800000, 1'b0, {3'b000, 32'h4B800002}});
        vecs.push_back('{32'h3F800000, 32'h33000000, 1'b0, {3'b000, 32'h3F800000}});
        vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {3'b010, 32'h7F800000}});
        vecs.push_back('{32'h7F800000, 32'h3F800000, 1'b0, {3'b100, 32'hFFFFFFFF}});
        vecs.push_back('{32'h00400000, 32'h00000000, 1'b0, {3'b000, 32'h00000000}});
        vecs.push_back('{32'h00800000, 32'h00800001, 1'b1, {3'b001, 32'h00000000}});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, {3'b000, 32'h00000000}});
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].s, 1'b1, vecs[i].r);
            drain();
        end

        // backpressure: 8 back-to-back ops with out_ready 1,0,0,1,0,0,...
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) issue_rnd(1'b0);
        drain();

        // randomized stream with random gaps and random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            issue_rnd(1'b0);
        end
        drain();

        // full-rate stream: simultaneous in/out transfers every cycle
        rdy_mode = 0;
        for (int i = 0; i < 20; i++) issue_rnd(1'b0);
        drain();

        // reset with three operations in flight
        for (int i = 0; i < 3; i++) issue_rnd(1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(32'h3F800000, 32'h40000000, 1'b0, 1'b1, {3'b000, 32'h40400000});
        drain();

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
